// File: rtl/i2s_master_ctrl.sv
`timescale 1ns/1ps
// Purpose: I2S master bit-clock / word-select generator with start and stop-at-frame-boundary control.
// Latency: busy and lrclk=0 one cycle after start; first sclk rise div+1 cycles after that.
// Backpressure: none; start/stop are single-cycle pulses, stop takes effect at the next frame wrap.
module i2s_master_ctrl #(
    parameter int DW        = 24,
    parameter int SLOT_BITS = 32,
    parameter int DIVW      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic [DIVW-1:0] div,
    output logic            sclk,
    output logic            lrclk,
    output logic            busy,
    output logic            frame_strobe,
    output logic [15:0]     frame_count
);
    localparam int BCW = $clog2(2 * SLOT_BITS);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(2 * SLOT_BITS - 1);
    localparam logic [BCW-1:0] SLOT_LAST = BCW'(SLOT_BITS - 1);

    if (SLOT_BITS < DW + 1 || SLOT_BITS > 64) begin : g_bad_slot
        $error("SLOT_BITS must lie in DW+1..64");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t          state;
    logic [1:0]      rst_sync;
    logic [DIVW-1:0] div_q;
    logic [DIVW-1:0] div_cnt;
    logic [BCW-1:0]  bit_cnt;
    logic            half_done;
    logic            fall_edge;
    logic            frame_wrap;

    // start is only honoured once reset release has passed through both flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign half_done  = (div_cnt == div_q);
    assign fall_edge  = half_done && sclk;
    assign frame_wrap = fall_edge && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sclk         <= 1'b0;
            lrclk        <= 1'b1;
            busy         <= 1'b0;
            frame_strobe <= 1'b0;
            frame_count  <= 16'd0;
            div_q        <= '0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
        end else begin
            frame_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (rst_sync[1] && start && !stop) begin
                        div_q       <= div;
                        div_cnt     <= '0;
                        bit_cnt     <= '0;
                        frame_count <= 16'd0;
                        sclk        <= 1'b0;
                        lrclk       <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (state == RUN && stop) state <= DRAIN;
                    if (half_done) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        // bit index and word select advance only as sclk falls
                        if (sclk) begin
                            bit_cnt <= frame_wrap ? '0 : bit_cnt + BCW'(1);
                            lrclk   <= !frame_wrap && (bit_cnt >= SLOT_LAST);
                        end
                        if (frame_wrap) begin
                            frame_strobe <= 1'b1;
                            frame_count  <= frame_count + 16'd1;
                            if (state == DRAIN) begin
                                sclk  <= 1'b0;
                                lrclk <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIVW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2s_master_ctrl.sv
`timescale 1ns/1ps
// Bench for i2s_master_ctrl: timing-formula reference model checked every cycle,
// behavioural I2S receiver on the generated clocks, directed literal checks and random runs.
module tb_i2s_master_ctrl;
    localparam int DW   = 24;
    localparam int S    = 32;
    localparam int DIVW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic [DIVW-1:0] div = '0;
    logic            sclk, lrclk, busy, frame_strobe;
    logic [15:0]     frame_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // reference model state: run start cycle, latched divider, drain deadline
    bit          m_busy  = 1'b0;
    bit          m_drain = 1'b0;
    int          m_t0 = 0, m_d = 0, m_dmin = 0, m_sync = 0;
    logic [15:0] m_count = 16'd0;

    // behavioural receiver
    logic [DW-1:0] lword, rword, sreg, ldata, rdata;
    logic          sdi = 1'b0, prev_sclk = 1'b0, tx_lr = 1'b1;
    int            tx_pos = 0, rx_valid = 0;

    int c0, a, b, e, x, v0, len;

    i2s_master_ctrl #(.DW(DW), .SLOT_BITS(S), .DIVW(DIVW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .div          (div),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .busy         (busy),
        .frame_strobe (frame_strobe),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected outputs from elapsed time since RUN entry: half period h=div+1, frame 4*S*h.
    task automatic model_cmp();
        logic [19:0] got, exp;
        logic e_sclk, e_lr, e_busy, e_str;
        int t, h, f;
        e_sclk = 1'b0; e_lr = 1'b1; e_busy = 1'b0; e_str = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0; m_drain = 1'b0; m_count = 16'd0; m_sync = 0;
        end else if (m_busy) begin
            h = m_d + 1;
            f = 4 * S * h;
            t = cyc - m_t0;
            if (t > 0 && t % f == 0) begin
                m_count++;
                e_str = 1'b1;
                if (m_drain && cyc >= m_dmin) m_busy = 1'b0;
            end
            if (m_busy) begin
                e_busy = 1'b1;
                e_sclk = ((t / h) % 2) == 1;
                e_lr   = ((t / (2 * h)) % (2 * S)) >= S;
            end
        end
        got = {sclk, lrclk, busy, frame_strobe, frame_count};
        exp = {e_sclk, e_lr, e_busy, e_str, m_count};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL model cycle %0d: got sclk=%b lrclk=%b busy=%b strobe=%b count=%0d, expected sclk=%b lrclk=%b busy=%b strobe=%b count=%0d",
                     cyc, sclk, lrclk, busy, frame_strobe, frame_count, e_sclk, e_lr, e_busy, e_str, m_count);
        end
    endtask

    // Inputs visible now are the ones sampled at the coming rising edge.
    task automatic model_step();
        if (rst_n) begin
            if (m_busy && !m_drain && stop) begin
                m_drain = 1'b1;
                m_dmin  = cyc + 2;
            end else if (!m_busy && m_sync >= 2 && start && !stop) begin
                m_busy  = 1'b1;
                m_t0    = cyc + 1;
                m_d     = int'(div);
                m_count = 16'd0;
                m_drain = 1'b0;
            end
            if (m_sync < 2) m_sync++;
        end
    endtask

    // I2S: MSB one bit after the word-select change, sdi changes on sclk fall, sampled on rise.
    task automatic rx_step();
        if (lrclk != tx_lr) begin
            tx_lr  = lrclk;
            tx_pos = 0;
        end else if (prev_sclk && !sclk) begin
            tx_pos++;
        end
        if (tx_pos >= 1 && tx_pos <= DW) sdi = lrclk ? rword[DW-tx_pos] : lword[DW-tx_pos];
        else                             sdi = 1'b0;
        if (!prev_sclk && sclk && tx_pos >= 1 && tx_pos <= DW) begin
            sreg = {sreg[DW-2:0], sdi};
            if (tx_pos == DW) begin
                if (!lrclk) ldata = sreg;
                else begin
                    rdata = sreg;
                    rx_valid++;
                    chk("rx_ldata", ldata, 64'hA5A5A5);
                    chk("rx_rdata", rdata, 64'h5A5A5A);
                end
            end
        end
        prev_sclk = sclk;
    endtask

    task automatic tick();
        @(negedge clk);
        model_cmp();
        rx_step();
        model_step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // sel: 0 sclk high, 1 lrclk high, 2 strobe, 3 idle, 4 sclk low
    task automatic run_until(input int sel, input int maxc, output int at);
        at = -1;
        for (int k = 0; k < maxc; k++) begin
            if ((sel == 0 && sclk) || (sel == 1 && lrclk) || (sel == 2 && frame_strobe) ||
                (sel == 3 && !busy) || (sel == 4 && !sclk)) begin
                at = cyc;
                break;
            end
            tick();
        end
    endtask

    initial begin
        lword = 'hA5A5A5;
        rword = 'h5A5A5A;
        sreg  = '0; ldata = '0; rdata = '0;
        @(posedge clk);
        #1;
        repeat (3) tick();
        chk("reset_busy", busy, 0);
        chk("reset_lrclk", lrclk, 1);
        chk("reset_sclk", sclk, 0);
        chk("reset_count", frame_count, 0);

        // start right after release is swallowed by the reset synchronizer
        rst_n = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("start_during_sync", busy, 0);
        repeat (3) tick();

        // div=1 frame timing
        c0 = cyc; div = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("c1_busy", busy, 1);
        chk("c1_lrclk", lrclk, 0);
        run_until(0, 100, a);  chk("first_rise", a - c0, 3);
        run_until(4, 100, x);
        run_until(0, 100, b);  chk("sclk_period_div1", b - a, 4);
        run_until(1, 400, x);  chk("lrclk_rise", x - c0, 129);
        run_until(2, 400, x);  chk("first_strobe", x - c0, 257);
        chk("count_after_1", frame_count, 1);

        // stop at bit 40 of frame 2: exactly one more strobe
        while (cyc < c0 + 417) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("drain_busy", busy, 1);
        run_until(2, 400, x);  chk("drain_strobe", x - c0, 513);
        chk("drain_end_busy", busy, 0);
        chk("drain_end_sclk", sclk, 0);
        chk("drain_end_lrclk", lrclk, 1);
        chk("drain_end_count", frame_count, 2);
        repeat (20) tick();
        chk("idle_count_hold", frame_count, 2);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        chk("startstop_busy", busy, 0);
        chk("startstop_sclk", sclk, 0);
        chk("startstop_lrclk", lrclk, 1);

        // div=0: clk/2, 128-cycle frames, stop coinciding with a wrap
        v0 = rx_valid;
        c0 = cyc; div = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        run_until(2, 300, a);  chk("div0_strobe1", a - c0, 129);
        chk("div0_count1", frame_count, 1);
        tick();
        run_until(2, 300, b);  chk("div0_frame_len", b - a, 128);
        chk("div0_count2", frame_count, 2);
        tick();
        run_until(2, 300, x);  chk("div0_count3", frame_count, 3);
        while (cyc < c0 + 512) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("wrapstop_strobe", frame_strobe, 1);
        chk("wrapstop_busy", busy, 1);
        run_until(3, 400, x);  chk("wrapstop_end", x - c0, 641);
        chk("wrapstop_count", frame_count, 5);
        chk("rx_valid_per_frame", rx_valid - v0, 5);

        // div change while running has no effect until the next start
        c0 = cyc; div = 8'd2; start = 1'b1;
        tick();
        start = 1'b0; div = 8'd7;
        run_until(0, 100, a);  chk("div2_first_rise", a - c0, 4);
        run_until(4, 100, x);
        run_until(0, 100, b);  chk("div2_period_kept", b - a, 6);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_until(3, 2000, x); chk("div2_idle", busy, 0);
        div = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        run_until(0, 100, a);
        run_until(4, 100, x);
        run_until(0, 100, b);  chk("restart_new_period", b - a, 10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        run_until(3, 4000, x); chk("div4_idle", busy, 0);

        // randomized runs: spurious starts/stops, div changes, occasional reset
        for (int it = 0; it < 25; it++) begin
            div = DIVW'($urandom_range(0, 2));
            start = 1'b1;
            tick();
            start = 1'b0;
            len = $urandom_range(100, 600);
            for (int k = 0; k < len; k++) begin
                start = ($urandom_range(0, 31) == 0);
                stop  = ($urandom_range(0, 63) == 0);
                if ($urandom_range(0, 15) == 0) div = DIVW'($urandom_range(0, 2));
                tick();
            end
            start = 1'b0;
            if ($urandom_range(0, 5) == 0) begin
                stop = 1'b0; rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                rst_n = 1'b1;
                repeat (3) tick();
            end else begin
                stop = 1'b1;
                tick();
                stop = 1'b0;
                run_until(3, 2000, x);
                chk("rand_drain_idle", busy, 0);
            end
        end

        // reset for 3 cycles at bit 50 of frame 2
        repeat (3) tick();
        c0 = cyc; div = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < c0 + 457) tick();
        chk("pre_reset_count", frame_count, 1);
        rst_n = 1'b0;
        #2;
        chk("async_rst_sclk", sclk, 0);
        chk("async_rst_lrclk", lrclk, 1);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_strobe", frame_strobe, 0);
        chk("async_rst_count", frame_count, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_reset_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_master_ctrl.md
I2S_MASTER_CTRL -- requirements
Module: i2s_master_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 24: sample width, in bits, expected by the attached I2S receiver.
REQ-002 The block SHALL have parameter SLOT_BITS, default 32: sclk periods per channel slot, with legal range DW+1..64.
REQ-003 The block SHALL have parameter DIVW, default 8: width of the divider input.
REQ-004 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: one-cycle pulse that requests clock generation.
REQ-007 The block SHALL have port stop, input, 1 bit: one-cycle pulse that requests a stop at the next frame boundary.
REQ-008 The block SHALL have port div, input, DIVW bits: sclk half-period, in clk cycles, minus 1.
REQ-009 The block SHALL have port sclk, output, 1 bit: generated bit clock.
REQ-010 The block SHALL have port lrclk, output, 1 bit: generated word select (0 = left, 1 = right).
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port frame_strobe, output, 1 bit: one-cycle pulse on completion of each frame.
REQ-013 The block SHALL have port frame_count, output, 16 bits: count of completed frames since the last start.

Function
REQ-014 The block SHALL implement states IDLE, RUN and DRAIN.
REQ-015 IDLE SHALL hold sclk=0 and lrclk=1, which are the receiver's idle levels.
REQ-016 When start=1 in IDLE, the block SHALL, on the next edge, latch div into div_q, clear frame_count, clear the divider and bit counters, set lrclk=0, keep sclk=0 and enter RUN.
REQ-017 When start=1 and stop=1 arrive in the same cycle in IDLE, stop SHALL win and the block SHALL stay in IDLE.
REQ-018 start SHALL be ignored in RUN and in DRAIN.
REQ-019 stop SHALL be ignored in IDLE and in DRAIN.
REQ-020 Divider: a counter SHALL count 0..div_q; at terminal count it wraps to 0 and sclk toggles, giving a half-period of div_q+1 clk cycles.
REQ-021 div_q=0 SHALL be legal and SHALL give sclk = clk/2.
REQ-022 A change on the div input SHALL have no effect until the next start.
REQ-023 Bit counter: a counter of width ceil(log2(2*SLOT_BITS)) SHALL increment on every sclk falling toggle and wrap from 2*SLOT_BITS-1 to 0.
REQ-024 lrclk SHALL update only on a sclk falling toggle: 0 for bit index 0..SLOT_BITS-1 and 1 for SLOT_BITS..2*SLOT_BITS-1.
REQ-025 The receiver samples on the rising edge, so sdi SHALL be stable for a full half-period before each rising edge.
REQ-026 On the falling toggle where the bit counter wraps, frame_strobe SHALL be 1 in the cycle after that edge, and frame_count SHALL increment in the same cycle.
REQ-027 frame_count SHALL wrap from 0xFFFF to 0.
REQ-028 A stop in RUN SHALL cause entry to DRAIN on the next edge; generation continues unchanged in DRAIN.
REQ-029 At the next frame wrap in DRAIN, the block SHALL emit frame_strobe, increment frame_count, force sclk=0 and lrclk=1, and enter IDLE.
REQ-030 A stop that coincides with a frame wrap SHALL cause one further full frame to be generated before IDLE.
REQ-031 Frame length SHALL be 4*SLOT_BITS*(div_q+1) clk cycles.
REQ-032 The first sclk rising toggle SHALL occur div_q+1 cycles after entry to RUN.
REQ-033 busy SHALL be registered, 1 in RUN and DRAIN, and 0 in the cycle IDLE is re-entered.

Reset
REQ-034 While rst_n=0, the block SHALL be in IDLE with sclk=0, lrclk=1, busy=0, frame_strobe=0, frame_count=0, div_q=0, and both counters at 0.
REQ-035 Assertion of rst_n mid-frame SHALL abort the frame immediately, with no frame_strobe.
REQ-036 Release of rst_n SHALL be used synchronously through a two-flop synchronizer, and no state SHALL leave IDLE before the first start after release.

Verification
REQ-037 With SLOT_BITS=32, div=1 and start at cycle 0, the bench SHALL see busy=1 and lrclk=0 at cycle 1, the first sclk rise at cycle 3, sclk period 4, lrclk rising at cycle 129 and frame_strobe at cycle 257.
REQ-038 With div=0, the bench SHALL see sclk toggle every cycle, a 128-cycle frame and frame_count incrementing 1, 2, 3 on successive strobes.
REQ-039 A stop at mid-frame (bit 40) SHALL produce exactly one more strobe, after which sclk=0, lrclk=1 and busy=0, and frame_count SHALL be final+0 until the next start.
REQ-040 start and stop in the same cycle in IDLE SHALL leave busy=0 and sclk and lrclk unchanged.
REQ-041 Changing div during RUN SHALL leave the sclk period unchanged; a restart after IDLE SHALL apply the new div.
REQ-042 With an i2s_rx instance attached and sdi driving 0xA5A5A5 on the left and 0x5A5A5A on the right, the bench SHALL see ldata=0xA5A5A5, rdata=0x5A5A5A and valid once per frame.
REQ-043 Pulling rst_n low for 3 cycles at bit 50 SHALL give outputs equal to the reset values immediately, with no strobe.
